int_controller: RTL and testbench
=================================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of interrupt channels (1..16); channel 0 is the highest priority.
REQ-002 Parameter ADDR_W, default 16, width of the return-address and vector buses.
REQ-003 Parameter DEPTH, default 4, maximum nesting depth (1..8).
REQ-004 Parameter VEC_BASE, default 16'hFF00, base address of the vector table.
REQ-005 The block has one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 irq  in  NUM_CH  level interrupt sources, one per channel, already synchronous to clk.
REQ-009 mask_we  in  1  write-enable for the mask register.
REQ-010 mask_wdata  in  NUM_CH  new mask value; a 1 bit disables that channel.
REQ-011 int_req  out  1  request to the control unit to take an interrupt.
REQ-012 int_vector  out  ADDR_W  handler address; stable while int_req is 1.
REQ-013 int_ack  in  1  the control unit accepts the request; sampled only while int_req is 1.
REQ-014 ret_addr_in  in  ADDR_W  PC to save, valid together with int_ack.
REQ-015 rit  in  1  return-from-interrupt strobe.
REQ-016 ret_addr_out  out  ADDR_W  top-of-stack return address; combinational; 0 when the stack is empty.
REQ-017 pending  out  NUM_CH  latched pending bits.
REQ-018 mask  out  NUM_CH  current mask register.
REQ-019 level  out  clog2(DEPTH+1)  current nesting depth.
REQ-020 err  out  1  sticky protocol-error flag.

Function
REQ-021 A rising edge on irq[i] is detected against a registered copy of irq and sets pending[i] on the following clock; an edge at cycle n gives pending at n+1.
REQ-022 pending[i] is set regardless of mask; masked channels are never selected.
REQ-023 The selected channel is the lowest-index bit of (pending & ~mask).
REQ-024 A channel is eligible when all of the following hold: the stack is empty, or the selected index is strictly lower than the active channel's index; and level < DEPTH.
REQ-025 The FSM has two states, IDLE and REQ.
REQ-026 IDLE -> REQ on the clock where a channel is eligible.
- The channel is latched on that clock.
- int_req goes to 1 and int_vector = VEC_BASE + channel (zero-extended, modulo 2^ADDR_W) on that same clock.
- An edge at cycle n therefore gives int_req at n+2.
REQ-027 In REQ, the channel and vector stay frozen until int_ack, even if a higher-priority request arrives.
REQ-028 REQ -> IDLE on int_ack:
- push {ret_addr_in, previous active channel};
- clear pending[channel], unless a new edge on that channel lands on the same clock, in which case the bit stays set;
- the channel becomes active and level increments.
REQ-029 rit with level > 0 pops the stack, restores the previous active channel and decrements level on the next clock; ret_addr_out is valid on the rit cycle itself.
REQ-030 rit with level = 0 is ignored and sets err.
REQ-031 int_ack and rit asserted on the same clock: rit is executed, the ack is ignored, FSM stays in REQ, err is set.
REQ-032 mask_we updates mask on the next clock. If the latched channel becomes masked while in REQ, the request is held until acked (no withdrawal).

Reset
REQ-033 On rst, at the next clock:
- pending, mask, level, err, the stack and the irq history are cleared;
- FSM goes to IDLE and int_req goes to 0;
- int_vector shows VEC_BASE.
REQ-034 A rst that coincides with int_ack or rit overrides both.

Configuration
REQ-035 Macro INT_CONTROLLER_NESTING_EN. Defined: preemption and stacking up to DEPTH as specified above. Undefined: effective depth is 1, so no request is raised while level = 1 and stack storage is a single entry.

Structure
REQ-036 Package int_pkg holds:
- the FSM state enum (IDLE, REQ);
- the NUM_CH/DEPTH limits;
- the default VEC_BASE.
REQ-037 One sub-module, int_prio_enc, is the parametrised lowest-index priority encoder (NUM_CH in, index and valid out).

Verification
REQ-038 The bench covers at least these five directed scenarios:
- Reset, then irq[3] 0->1 at cycle 10 -> pending[3] at 11; int_req with int_vector 16'hFF03 at 12; ack with ret_addr_in 16'h0123 -> level 1, ret_addr_out 16'h0123.
- irq[5] and irq[2] rise on the same clock -> vector 16'hFF02 first; after its ack, no request for 5 until rit; then vector 16'hFF05.
- Active channel 4, irq[1] rises -> nested request 16'hFF01, level 2 after ack; two rits return the pushed addresses in LIFO order.
- DEPTH = 2 with both levels full and irq[0] rising -> int_req stays 0 until rit.
- rit at level 0 -> err = 1, level stays 0; int_ack together with rit -> FSM stays REQ, err = 1.

Source files
------------

// File: rtl/int_controller_pkg.sv
// Shared types and limits for the priority interrupt controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package int_pkg;

    // Request FSM: IDLE scans for an eligible channel, REQ holds it until acked.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } int_state_e;

    // Legal parameter ranges.
    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 16;
    localparam int DEPTH_MIN  = 1;
    localparam int DEPTH_MAX  = 8;

    // Default base address of the vector table.
    localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFF00;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_controller_if.sv
// Bundle of the controller's source, mask, CPU handshake and status signals.
// Latency: none (wiring only).
// Backpressure: int_req is held until the CPU returns int_ack.
interface int_controller_if #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) ();

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0] irq;
    logic              mask_we;
    logic [NUM_CH-1:0] mask_wdata;
    logic              int_req;
    logic [ADDR_W-1:0] int_vector;
    logic              int_ack;
    logic [ADDR_W-1:0] ret_addr_in;
    logic              rit;
    logic [ADDR_W-1:0] ret_addr_out;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] mask;
    logic [LVL_W-1:0]  level;
    logic              err;

    // CPU / environment side.
    modport master (
        output irq, mask_we, mask_wdata, int_ack, ret_addr_in, rit,
        input  int_req, int_vector, ret_addr_out, pending, mask, level, err
    );

    // Controller side.
    modport slave (
        input  irq, mask_we, mask_wdata, int_ack, ret_addr_in, rit,
        output int_req, int_vector, ret_addr_out, pending, mask, level, err
    );

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over a request vector.
// Latency: combinational.
// Backpressure: none; o_vld is low when no request bit is set.
module int_prio_enc #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Nested priority interrupt controller with return-address stack (INT_CONTROLLER_NESTING_EN enables preemption).
// Latency: irq edge at n -> pending at n+1 -> int_req/int_vector at n+2; ret_addr_out is combinational.
// Backpressure: a raised request and its vector stay frozen until int_ack; no withdrawal.
module int_controller
    import int_pkg::*;
#(
    parameter int                NUM_CH   = 8,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(VEC_BASE_DEFAULT)
) (
    input logic             clk,
    input logic             rst,
    int_controller_if.slave io_bus
);

    localparam int CH_W  = ch_idx_w(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef INT_CONTROLLER_NESTING_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    // Without nesting only one handler can be in flight at a time.
    localparam int EFF_DEPTH = 1;
`endif
    localparam int STK_W = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;

    // Source history, pending and mask state.
    logic [NUM_CH-1:0] r_irq_q;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_mask;

    // Request FSM state and its registered outputs.
    int_state_e        r_state;
    logic [CH_W-1:0]   r_chan;
    logic              r_int_req;
    logic [ADDR_W-1:0] r_vector;

    // Nesting state: depth, running channel and the save stack.
    logic [LVL_W-1:0]  r_level;
    logic [CH_W-1:0]   r_active;
    logic              r_err;
    logic [ADDR_W-1:0] r_stk_addr [EFF_DEPTH];
    logic [CH_W-1:0]   r_stk_ch   [EFF_DEPTH];

    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_avail;
    logic [NUM_CH-1:0] w_clr;
    logic [CH_W-1:0]   w_sel_idx;
    logic              w_sel_vld;
    logic              w_stk_empty;
    logic              w_room;
    logic              w_eligible;
    logic              w_in_req;
    logic              w_ack;
    logic              w_clash;
    logic              w_do_rit;
    logic              w_rit_err;
    logic [STK_W-1:0]  w_push_idx;
    logic [STK_W-1:0]  w_top_idx;

    assign w_edge  = io_bus.irq & ~r_irq_q;
    assign w_avail = r_pending & ~r_mask;

    int_prio_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_prio_enc (
        .i_req (w_avail),
        .o_idx (w_sel_idx),
        .o_vld (w_sel_vld)
    );

    assign w_stk_empty = (r_level == '0);
    assign w_room      = (int'(r_level) < EFF_DEPTH);
    // A new request must strictly out-rank the running handler and fit on the stack.
    assign w_eligible  = w_sel_vld && (w_stk_empty || (w_sel_idx < r_active)) && w_room;

    // int_ack only counts while a request is up; rit on the same clock wins over it.
    assign w_in_req  = (r_state == REQ);
    assign w_ack     = w_in_req && io_bus.int_ack && !io_bus.rit;
    assign w_clash   = w_in_req && io_bus.int_ack && io_bus.rit;
    assign w_do_rit  = io_bus.rit && !w_stk_empty;
    assign w_rit_err = io_bus.rit && w_stk_empty;

    assign w_push_idx = STK_W'(r_level);
    assign w_top_idx  = STK_W'(r_level - LVL_W'(1));

    // One-hot clear of the acknowledged channel's pending bit.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clr[i] = w_ack && (r_chan == CH_W'(i));
        end
    end

    // Edge detection, pending latch (a same-clock edge beats the ack clear) and mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_irq_q   <= io_bus.irq;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (io_bus.mask_we) begin
                r_mask <= io_bus.mask_wdata;
            end
        end
    end

    // Request FSM: latch the winning channel and vector, hold them until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_chan    <= '0;
            r_int_req <= 1'b0;
            r_vector  <= VEC_BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_eligible) begin
                        r_state   <= REQ;
                        r_chan    <= w_sel_idx;
                        r_int_req <= 1'b1;
                        r_vector  <= VEC_BASE + ADDR_W'(w_sel_idx);
                    end
                end
                REQ: begin
                    if (w_ack) begin
                        r_state   <= IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    // Save stack: push on ack, pop on rit, flag protocol errors stickily.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level  <= '0;
            r_active <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < EFF_DEPTH; i++) begin
                r_stk_addr[i] <= '0;
                r_stk_ch[i]   <= '0;
            end
        end else begin
            if (w_ack) begin
                r_stk_addr[w_push_idx] <= io_bus.ret_addr_in;
                r_stk_ch[w_push_idx]   <= r_active;
                r_active               <= r_chan;
                r_level                <= r_level + LVL_W'(1);
            end else if (w_do_rit) begin
                r_active <= r_stk_ch[w_top_idx];
                r_level  <= r_level - LVL_W'(1);
            end
            if (w_rit_err || w_clash) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_bus.int_req      = r_int_req;
    assign io_bus.int_vector   = r_vector;
    assign io_bus.ret_addr_out = w_stk_empty ? '0 : r_stk_addr[w_top_idx];
    assign io_bus.pending      = r_pending;
    assign io_bus.mask         = r_mask;
    assign io_bus.level        = r_level;
    assign io_bus.err          = r_err;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: latency, priority, nesting, depth limit, masking, errors.
// Latency: inputs driven after the falling edge, outputs sampled at the following falling edge.
// Backpressure: the bench plays the CPU and acks/rits explicitly.
module tb_int_controller;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    int_controller_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bus ();

    int_controller #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .VEC_BASE (16'hFF00)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_ack(input logic [15:0] addr);
        u_bus.int_ack     = 1'b1;
        u_bus.ret_addr_in = addr;
        step();
        u_bus.int_ack     = 1'b0;
    endtask

    task automatic do_rit();
        u_bus.rit = 1'b1;
        step();
        u_bus.rit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        u_bus.irq        = '0;
        u_bus.mask_we    = 1'b0;
        u_bus.mask_wdata = '0;
        u_bus.int_ack    = 1'b0;
        u_bus.ret_addr_in = '0;
        u_bus.rit        = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state.
        chk("rst_req",   32'(u_bus.int_req), 32'h0);
        chk("rst_vec",   32'(u_bus.int_vector), 32'hFF00);
        chk("rst_pend",  32'(u_bus.pending), 32'h00);
        chk("rst_mask",  32'(u_bus.mask), 32'h00);
        chk("rst_level", 32'(u_bus.level), 32'h0);
        chk("rst_err",   32'(u_bus.err), 32'h0);
        chk("rst_ret",   32'(u_bus.ret_addr_out), 32'h0);

        // Single channel: edge -> pending -> request, then ack and return.
        step(8);
        u_bus.irq[3] = 1'b1;
        step();
        chk("s1_pend",     32'(u_bus.pending), 32'h08);
        chk("s1_req_early", 32'(u_bus.int_req), 32'h0);
        step();
        chk("s1_req",  32'(u_bus.int_req), 32'h1);
        chk("s1_vec",  32'(u_bus.int_vector), 32'hFF03);
        do_ack(16'h0123);
        chk("s1_level", 32'(u_bus.level), 32'h1);
        chk("s1_ret",   32'(u_bus.ret_addr_out), 32'h0123);
        chk("s1_req_dn", 32'(u_bus.int_req), 32'h0);
        chk("s1_pclr",  32'(u_bus.pending), 32'h00);
        step();
        chk("s1_no_rereq", 32'(u_bus.int_req), 32'h0);
        do_rit();
        chk("s1_lvl0", 32'(u_bus.level), 32'h0);
        chk("s1_ret0", 32'(u_bus.ret_addr_out), 32'h0);
        u_bus.irq = '0;
        step();

        // Two simultaneous sources: lower index first, the other waits for rit.
        u_bus.irq[5] = 1'b1;
        u_bus.irq[2] = 1'b1;
        step();
        chk("s2_pend", 32'(u_bus.pending), 32'h24);
        step();
        chk("s2_vec2", 32'(u_bus.int_vector), 32'hFF02);
        do_ack(16'h0200);
        chk("s2_level", 32'(u_bus.level), 32'h1);
        chk("s2_pend5", 32'(u_bus.pending), 32'h20);
        step(3);
        chk("s2_hold5", 32'(u_bus.int_req), 32'h0);
        do_rit();
        chk("s2_lvl0", 32'(u_bus.level), 32'h0);
        chk("s2_req_pre", 32'(u_bus.int_req), 32'h0);
        step();
        chk("s2_req5", 32'(u_bus.int_req), 32'h1);
        chk("s2_vec5", 32'(u_bus.int_vector), 32'hFF05);
        do_ack(16'h0500);
        do_rit();
        u_bus.irq = '0;
        step();

        // Channel 4 running, channel 1 arrives.
        u_bus.irq[4] = 1'b1;
        step(2);
        chk("s3_vec4", 32'(u_bus.int_vector), 32'hFF04);
        do_ack(16'h0400);
        chk("s3_lvl1", 32'(u_bus.level), 32'h1);
        u_bus.irq[1] = 1'b1;
        step();
        chk("s3_pend1", 32'(u_bus.pending), 32'h02);
`ifdef INT_CONTROLLER_NESTING_EN
        step();
        chk("s3_nreq", 32'(u_bus.int_req), 32'h1);
        chk("s3_nvec", 32'(u_bus.int_vector), 32'hFF01);
        do_ack(16'h0111);
        chk("s3_lvl2", 32'(u_bus.level), 32'h2);
        chk("s3_ret2", 32'(u_bus.ret_addr_out), 32'h0111);
        // Stack full: channel 0 must wait.
        u_bus.irq[0] = 1'b1;
        step();
        chk("s4_pend0", 32'(u_bus.pending), 32'h01);
        step(3);
        chk("s4_full", 32'(u_bus.int_req), 32'h0);
        do_rit();
        chk("s4_lvl1", 32'(u_bus.level), 32'h1);
        chk("s4_lifo1", 32'(u_bus.ret_addr_out), 32'h0400);
        chk("s4_req_pre", 32'(u_bus.int_req), 32'h0);
        step();
        chk("s4_req0", 32'(u_bus.int_req), 32'h1);
        chk("s4_vec0", 32'(u_bus.int_vector), 32'hFF00);
        do_ack(16'h0AAA);
        chk("s4_ret", 32'(u_bus.ret_addr_out), 32'h0AAA);
        do_rit();
        chk("s3_lifo_a", 32'(u_bus.ret_addr_out), 32'h0400);
        do_rit();
        chk("s3_lifo_b", 32'(u_bus.ret_addr_out), 32'h0000);
        chk("s3_lvl0", 32'(u_bus.level), 32'h0);
`else
        // Depth 1: nothing is raised while a handler runs.
        step(3);
        chk("s3_nonest", 32'(u_bus.int_req), 32'h0);
        u_bus.irq[0] = 1'b1;
        step(2);
        chk("s4_pend01", 32'(u_bus.pending), 32'h03);
        chk("s4_full", 32'(u_bus.int_req), 32'h0);
        do_rit();
        chk("s4_lvl0", 32'(u_bus.level), 32'h0);
        step();
        chk("s4_vec0", 32'(u_bus.int_vector), 32'hFF00);
        do_ack(16'h0AAA);
        chk("s4_lvl1", 32'(u_bus.level), 32'h1);
        chk("s4_ret", 32'(u_bus.ret_addr_out), 32'h0AAA);
        do_rit();
        step();
        chk("s3_vec1", 32'(u_bus.int_vector), 32'hFF01);
        do_ack(16'h0111);
        do_rit();
        chk("s3_lvl0", 32'(u_bus.level), 32'h0);
`endif
        u_bus.irq = '0;
        step(2);

        // Protocol errors.
        do_rit();
        chk("s5_err", 32'(u_bus.err), 32'h1);
        chk("s5_lvl", 32'(u_bus.level), 32'h0);
        do_reset();
        chk("s5_err_clr", 32'(u_bus.err), 32'h0);
        u_bus.irq[6] = 1'b1;
        step(2);
        chk("s5_vec6", 32'(u_bus.int_vector), 32'hFF06);
        u_bus.int_ack = 1'b1;
        u_bus.rit     = 1'b1;
        step();
        u_bus.int_ack = 1'b0;
        u_bus.rit     = 1'b0;
        chk("s5_clash_req", 32'(u_bus.int_req), 32'h1);
        chk("s5_clash_vec", 32'(u_bus.int_vector), 32'hFF06);
        chk("s5_clash_err", 32'(u_bus.err), 32'h1);
        chk("s5_clash_lvl", 32'(u_bus.level), 32'h0);
        do_ack(16'h0600);
        chk("s5_lvl1", 32'(u_bus.level), 32'h1);
        chk("s5_ret", 32'(u_bus.ret_addr_out), 32'h0600);
        do_rit();
        u_bus.irq = '0;
        step();

        // Masking: pending still latches, selection waits for unmask; mask in REQ does not withdraw.
        u_bus.mask_we    = 1'b1;
        u_bus.mask_wdata = 8'h04;
        step();
        u_bus.mask_we    = 1'b0;
        chk("m_mask", 32'(u_bus.mask), 32'h04);
        u_bus.irq[2] = 1'b1;
        step();
        chk("m_pend", 32'(u_bus.pending), 32'h04);
        step(2);
        chk("m_blocked", 32'(u_bus.int_req), 32'h0);
        u_bus.mask_we    = 1'b1;
        u_bus.mask_wdata = 8'h00;
        step();
        u_bus.mask_we    = 1'b0;
        chk("m_unmask", 32'(u_bus.mask), 32'h00);
        step();
        chk("m_req", 32'(u_bus.int_req), 32'h1);
        chk("m_vec", 32'(u_bus.int_vector), 32'hFF02);
        u_bus.mask_we    = 1'b1;
        u_bus.mask_wdata = 8'hFF;
        u_bus.irq[2]     = 1'b0;
        step();
        u_bus.mask_we    = 1'b0;
        chk("m_held_req", 32'(u_bus.int_req), 32'h1);
        chk("m_held_vec", 32'(u_bus.int_vector), 32'hFF02);
        // New edge on the acked channel in the ack clock keeps its pending bit.
        u_bus.irq[2] = 1'b1;
        do_ack(16'h0222);
        chk("m_ack_lvl", 32'(u_bus.level), 32'h1);
        chk("m_keep_pend", 32'(u_bus.pending), 32'h04);
        step(2);
        chk("m_masked_idle", 32'(u_bus.int_req), 32'h0);

        // Reset coinciding with rit overrides it.
        rst       = 1'b1;
        u_bus.rit = 1'b1;
        step();
        rst       = 1'b0;
        u_bus.rit = 1'b0;
        chk("r_lvl", 32'(u_bus.level), 32'h0);
        chk("r_pend", 32'(u_bus.pending), 32'h00);
        chk("r_mask", 32'(u_bus.mask), 32'h00);
        chk("r_err", 32'(u_bus.err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
